mul_operand_feeder: RTL and testbench

//  Upstream stage of the repeated-addition multiplier. Accepts operand pairs

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_feed_fifo.sv | 74 +++++++
 rtl/mul_operand_feeder.sv | 183 ++++++++++++++++++
 tb/tb_mul_operand_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the repeated-addition multiplier front end:
//   feeder FSM state encodings and the default operand width.
// -----------------------------------------------------------------------------
package mul_pkg;

  // Default operand width, also the width of the shared data_in bus.
  localparam int DEF_WIDTH = 16;

  // Feeder controller states (3-bit encoding).
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_FEED_B  = 3'd2,
    S_WAIT    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

endpackage : mul_pkg

// File: rtl/mul_feed_fifo.sv
// -----------------------------------------------------------------------------
// mul_feed_fifo
//   Synchronous show-ahead FIFO of {a,b} operand pairs. Full/empty are decoded
//   from a registered occupancy count, so a pop never frees space for a push
//   in the same cycle.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata (ignored when full)
//   wdata  in   {a,b} pair, 2*WIDTH bits
//   pop    in   discard the head entry (ignored when empty)
//   head   out  current head entry, valid while empty==0
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module mul_feed_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic               pop,
  output logic [2*WIDTH-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CNTW-1:0]    count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == {CNTW{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CNTW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule : mul_feed_fifo

// File: rtl/mul_operand_feeder.sv
// -----------------------------------------------------------------------------
// mul_operand_feeder
//   Front end of the repeated-addition multiplier. Buffers operand pairs,
//   launches one multiply at a time on the shared data_in bus (A while the
//   core loads A, B while it loads B), waits for done, then re-arms the core
//   with a one-cycle core_rst pulse. Pairs with a zero operand are dropped
//   and flagged on zero_skip. A stuck launch is aborted after TIMEOUT cycles
//   in START or FEED_B and flagged on err.
// Ports
//   clk, rst           clock / synchronous active-high reset
//   in_valid, in_ready operand pair handshake (in_ready = FIFO not full)
//   in_a, in_b         multiplicand / multiplier
//   data_in            shared operand bus to the datapath
//   start              launch request (high in START)
//   core_rst           core re-arm pulse, also high while rst is high
//   ld_a, ld_b, done   core status inputs
//   busy               multiply in flight (state != IDLE)
//   zero_skip, err     one-cycle event pulses
// -----------------------------------------------------------------------------
module mul_operand_feeder
  import mul_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] data_in,
  output logic             start,
  output logic             core_rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             done,
  output logic             busy,
  output logic             zero_skip,
  output logic             err
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  // Counter value in the TIMEOUT-th cycle of a state (counter starts at 0).
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hold_b;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head_zero;
  logic               timed_out;

  assign head_a    = head[2*WIDTH-1:WIDTH];
  assign head_b    = head[WIDTH-1:0];
  assign head_zero = (head_a == {WIDTH{1'b0}}) || (head_b == {WIDTH{1'b0}});
  assign timed_out = (cnt == LAST);
  assign push      = in_valid && !full;
  assign in_ready  = !full;

  mul_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Head is consumed on a zero-operand drop, on ld_b, or on a timeout abort.
  // In START, ld_a wins over a coincident timeout and the pair is kept.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && head_zero) pop = 1'b1;
        else                     pop = 1'b0;
      end
      S_START: begin
        if (!ld_a && timed_out) pop = 1'b1;
        else                    pop = 1'b0;
      end
      S_FEED_B: begin
        if (ld_b || timed_out) pop = 1'b1;
        else                   pop = 1'b0;
      end
      default: pop = 1'b0;
    endcase
  end

  // Operand bus mux: B is taken from the hold register once its entry is popped.
  always_comb begin
    data_in = {WIDTH{1'b0}};
    case (state)
      S_START:  data_in = head_a;
      S_FEED_B: data_in = head_b;
      S_WAIT:   data_in = hold_b;
      default:  data_in = {WIDTH{1'b0}};
    endcase
  end

  assign start    = (state == S_START);
  assign busy     = (state != S_IDLE);
  assign core_rst = rst || (state == S_RECOVER);

  // Launch FSM with per-state cycle counter, B hold register and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= {CW{1'b0}};
      hold_b    <= {WIDTH{1'b0}};
      zero_skip <= 1'b0;
      err       <= 1'b0;
    end else begin
      zero_skip <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= {CW{1'b0}};
          if (!empty) begin
            if (head_zero) begin
              zero_skip <= 1'b1;
            end else begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          if (ld_a) begin
            state <= S_FEED_B;
            cnt   <= {CW{1'b0}};
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= S_RECOVER;
            cnt   <= {CW{1'b0}};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FEED_B: begin
          if (ld_b) begin
            hold_b <= head_b;
            state  <= S_WAIT;
            cnt    <= {CW{1'b0}};
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= S_RECOVER;
            cnt   <= {CW{1'b0}};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          cnt <= {CW{1'b0}};
          if (done) begin
            state <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          cnt   <= {CW{1'b0}};
          state <= S_IDLE;
        end
        default: begin
          cnt   <= {CW{1'b0}};
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : mul_operand_feeder

// File: tb/tb_mul_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_mul_operand_feeder
//   Directed bench with a behavioural core: ld_a one cycle after start, ld_b
//   one cycle after ld_a, done after B+1 counting cycles, then parked until
//   core_rst. A negedge monitor logs bus values and event counts.
// -----------------------------------------------------------------------------
module tb_mul_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [15:0] data_in;
  logic        start;
  logic        core_rst;
  logic        ld_a;
  logic        ld_b;
  logic        done;
  logic        busy;
  logic        zero_skip;
  logic        err;

  int checks = 0;
  int errors = 0;

  mul_operand_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .data_in   (data_in),
    .start     (start),
    .core_rst  (core_rst),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .done      (done),
    .busy      (busy),
    .zero_skip (zero_skip),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural core
  int          cst = 0;
  logic [15:0] rem = 16'd0;
  logic        stall_a = 1'b0;

  assign ld_a = (cst == 1);
  assign ld_b = (cst == 2);
  assign done = (cst == 4);

  always @(posedge clk) begin
    if (core_rst) begin
      cst <= 0;
      rem <= 16'd0;
    end else begin
      case (cst)
        0: if (start && !stall_a) cst <= 1;
        1: cst <= 2;
        2: begin rem <= data_in; cst <= 3; end
        3: if (rem == 16'd0) cst <= 4; else rem <= rem - 16'd1;
        4: cst <= 5;
        default: cst <= cst;
      endcase
    end
  end

  // Monitor
  logic [15:0] a_q[$];
  logic [15:0] b_q[$];
  int   n_start = 0;
  int   n_zs = 0;
  int   n_err = 0;
  int   n_crst = 0;
  logic start_d = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ld_a) a_q.push_back(data_in);
      if (ld_b) b_q.push_back(data_in);
      if (start && !start_d) n_start++;
      if (zero_skip) n_zs++;
      if (err) n_err++;
      if (core_rst) n_crst++;
    end
    start_d = start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        step();
        ok = 1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: pair (%0d,%0d) not accepted, required accept within 400 cycles", a, b);
    end
  endtask

  // Step until n_crst reaches target, then one more cycle so the FSM is back in IDLE.
  task automatic wait_tx(input int target);
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (n_crst >= target) begin ok = 1; break; end
      step();
    end
    step();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_tx: core_rst pulses %0d, required %0d", n_crst, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", start); end
    rst = 1'b0;
    step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start_after: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (zero_skip !== 1'b0) begin errors++; $display("FAIL rst_zero_skip: got %b want 0", zero_skip); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (data_in !== 16'd0) begin errors++; $display("FAIL rst_data_in: got %0d want 0", data_in); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL rst_core_rst_rel: got %b want 0", core_rst); end
  endtask

  task automatic test_basic();
    int qa = a_q.size();
    int qb = b_q.size();
    int s0 = n_start;
    int c0 = n_crst;
    int nbusy = 0;
    bit busy_bad = 0;
    push(16'd5, 16'd3);
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL basic_start_latency: start %b want 1", start); end
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) busy_bad = 1;
      nbusy++;
      if (core_rst === 1'b1) break;
      step();
    end
    checks++; if (busy_bad) begin errors++; $display("FAIL basic_busy_held: busy dropped, want 1 throughout"); end
    checks++; if (nbusy != 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", nbusy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %b want 0", busy); end
    checks++; if (n_crst - c0 != 1) begin errors++; $display("FAIL basic_core_rst: pulses %0d want 1", n_crst - c0); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL basic_starts: got %0d want 1", n_start - s0); end
    checks++; if (a_q.size() != qa + 1 || a_q[qa] !== 16'd5) begin errors++; $display("FAIL basic_a: got %0d want 5", (a_q.size() > qa) ? a_q[qa] : 16'hFFFF); end
    checks++; if (b_q.size() != qb + 1 || b_q[qb] !== 16'd3) begin errors++; $display("FAIL basic_b: got %0d want 3", (b_q.size() > qb) ? b_q[qb] : 16'hFFFF); end
  endtask

  task automatic test_zero_skip();
    int qa = a_q.size();
    int qb = b_q.size();
    int s0 = n_start;
    int z0 = n_zs;
    int c0 = n_crst;
    push(16'd7, 16'd0);
    push(16'd4, 16'd2);
    wait_tx(c0 + 1);
    checks++; if (n_zs - z0 != 1) begin errors++; $display("FAIL zs_pulses: got %0d want 1", n_zs - z0); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL zs_starts: got %0d want 1", n_start - s0); end
    checks++; if (a_q.size() != qa + 1 || a_q[qa] !== 16'd4) begin errors++; $display("FAIL zs_a: got %0d want 4", (a_q.size() > qa) ? a_q[qa] : 16'hFFFF); end
    checks++; if (b_q.size() != qb + 1 || b_q[qb] !== 16'd2) begin errors++; $display("FAIL zs_b: got %0d want 2", (b_q.size() > qb) ? b_q[qb] : 16'hFFFF); end
  endtask

  task automatic test_burst();
    logic [15:0] ea [4] = '{16'd3, 16'd6, 16'd9, 16'd2};
    logic [15:0] eb [4] = '{16'd1, 16'd2, 16'd1, 16'd3};
    int qa = a_q.size();
    int qb = b_q.size();
    int s0 = n_start;
    int c0 = n_crst;
    bit seen = 0;
    push(ea[0], eb[0]);
    push(ea[1], eb[1]);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_full: in_ready %b want 0", in_ready); end
    in_valid = 1'b1;
    in_a = ea[2];
    in_b = eb[2];
    for (int i = 0; i < 50; i++) begin
      if (ld_b === 1'b1) begin seen = 1; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL burst_ld_b: ld_b not seen, want within 50 cycles"); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pop_full_ready: in_ready %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_full_count: in_ready %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refill: in_ready %b want 0", in_ready); end
    push(ea[3], eb[3]);
    wait_tx(c0 + 4);
    checks++; if (n_start - s0 != 4) begin errors++; $display("FAIL burst_starts: got %0d want 4", n_start - s0); end
    checks++; if (a_q.size() - qa != 4 || b_q.size() - qb != 4) begin errors++; $display("FAIL burst_count: got %0d/%0d want 4/4", a_q.size() - qa, b_q.size() - qb); end
    for (int k = 0; k < 4; k++) begin
      if (a_q.size() > qa + k && b_q.size() > qb + k) begin
        checks++;
        if (a_q[qa + k] !== ea[k] || b_q[qb + k] !== eb[k]) begin
          errors++;
          $display("FAIL burst_order%0d: got (%0d,%0d) want (%0d,%0d)", k, a_q[qa + k], b_q[qb + k], ea[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int qa = a_q.size();
    int e0 = n_err;
    int c0 = n_crst;
    int n = 0;
    bit seen = 0;
    stall_a = 1'b1;
    push(16'd8, 16'd2);
    for (int i = 0; i < 10; i++) begin
      if (start === 1'b1) begin seen = 1; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_start: start not seen, want within 10 cycles"); end
    while (start === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++; if (n != 64) begin errors++; $display("FAIL to_cycles: start high %0d cycles want 64", n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: err %b want 1", err); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL to_core_rst: core_rst %b want 1", core_rst); end
    stall_a = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: err %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy %b want 0", busy); end
    checks++; if (a_q.size() != qa) begin errors++; $display("FAIL to_no_load: ld_a count %0d want 0", a_q.size() - qa); end
    push(16'd5, 16'd1);
    wait_tx(c0 + 2);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", n_err - e0); end
    checks++; if (a_q.size() != qa + 1 || a_q[qa] !== 16'd5) begin errors++; $display("FAIL to_next_a: got %0d want 5", (a_q.size() > qa) ? a_q[qa] : 16'hFFFF); end
  endtask

  task automatic test_reset_midop();
    int s0;
    bit seen = 0;
    push(16'd4, 16'd6);
    push(16'd3, 16'd3);
    for (int i = 0; i < 50; i++) begin
      if (ld_b === 1'b1) begin seen = 1; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_ld_b: ld_b not seen, want within 50 cycles"); end
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_in_wait: busy %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rm_core_rst: got %b want 1", core_rst); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: busy %b want 0", busy); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rm_start: start %b want 0", start); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    step();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rm_core_rst_hold: got %b want 1", core_rst); end
    rst = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 6; i++) step();
    checks++; if (n_start != s0 || start !== 1'b0) begin errors++; $display("FAIL rm_fifo_empty: starts %0d want 0", n_start - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after: busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skip();
    test_burst();
    test_timeout();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mul_operand_feeder
